// File: rtl/address_generation_unit.sv
// Program counter and external address mux, with an optional reset-vector fetch.
// Define VECTOR_FETCH_EN to load the PC from VECTOR_ADDR/VECTOR_ADDR+1 after reset.
module address_generation_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        clk_enable,
  input  logic        pc_enable,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic [1:0]  address_select,
  input  logic [15:0] memory_address,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  data_in,
  output logic [15:0] address_out,
  output logic [15:0] pc_out,
  output logic        vector_busy
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] run_pc;
  logic [15:0] run_addr;

  // Load beats increment; increment wraps naturally in 16 bits.
  always_comb begin
    if (pc_load)        run_pc = pc_load_value;
    else if (pc_enable) run_pc = pc_q + 16'd1;
    else                run_pc = pc_q;
  end

  always_comb begin
    case (address_select)
      2'd1:    run_addr = memory_address;
      2'd2:    run_addr = {8'h00, alu_result};
      default: run_addr = pc_q;
    endcase
  end

  assign pc_out = pc_q;

`ifdef VECTOR_FETCH_EN
  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_VEC_LO = 2'd1,
    S_VEC_HI = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] vec_lo_q, vec_lo_d;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    vec_lo_d = vec_lo_q;
    pc_d     = pc_q;
    if (clk_enable) begin
      case (state_q)
        S_VEC_LO: begin
          vec_lo_d = data_in;
          state_d  = S_VEC_HI;
        end
        S_VEC_HI: begin
          pc_d    = {data_in, vec_lo_q};
          state_d = S_RUN;
        end
        S_RUN:   pc_d    = run_pc;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_VEC_LO: address_out = VECTOR_ADDR;
      S_VEC_HI: address_out = VECTOR_ADDR + 16'd1;
      default:  address_out = run_addr;
    endcase
  end

  assign vector_busy = (state_q == S_VEC_LO) || (state_q == S_VEC_HI);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= S_VEC_LO;
      vec_lo_q <= 8'h00;
      pc_q     <= RESET_PC;
    end else begin
      state_q  <= state_d;
      vec_lo_q <= vec_lo_d;
      pc_q     <= pc_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{data_in, VECTOR_ADDR};

  assign pc_d        = clk_enable ? run_pc : pc_q;
  assign address_out = run_addr;
  assign vector_busy = 1'b0;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end
`endif

endmodule

// File: tb/tb_address_generation_unit.sv
// Directed scoreboard bench for address_generation_unit; builds with or without VECTOR_FETCH_EN.
module tb_address_generation_unit;

  logic        clk = 1'b0;
  logic        res_n;
  logic        clk_enable;
  logic        pc_enable;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [1:0]  address_select;
  logic [15:0] memory_address;
  logic [7:0]  alu_result;
  logic [7:0]  data_in;
  logic [15:0] address_out;
  logic [15:0] pc_out;
  logic        vector_busy;

  typedef enum logic [1:0] {SIG_PC, SIG_ADDR, SIG_BUSY} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  address_generation_unit dut (
    .clk            (clk),
    .res_n          (res_n),
    .clk_enable     (clk_enable),
    .pc_enable      (pc_enable),
    .pc_load        (pc_load),
    .pc_load_value  (pc_load_value),
    .address_select (address_select),
    .memory_address (memory_address),
    .alu_result     (alu_result),
    .data_in        (data_in),
    .address_out    (address_out),
    .pc_out         (pc_out),
    .vector_busy    (vector_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input sig_e sig, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  // Pops every pending expectation and compares it with the live DUT output.
  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        SIG_PC:   obs = pc_out;
        SIG_ADDR: obs = address_out;
        default:  obs = {15'd0, vector_busy};
      endcase
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    res_n          = 1'b0;
    clk_enable     = 1'b1;
    pc_enable      = 1'b0;
    pc_load        = 1'b0;
    pc_load_value  = 16'h0000;
    address_select = 2'd0;
    memory_address = 16'h0000;
    alu_result     = 8'h00;
    data_in        = 8'h00;
    #12;

    push("reset_pc", SIG_PC, 16'h0000);
`ifdef VECTOR_FETCH_EN
    push("reset_busy", SIG_BUSY, 16'd1);
    push("reset_addr", SIG_ADDR, 16'hFFFC);
`else
    push("reset_busy", SIG_BUSY, 16'd0);
    push("reset_addr", SIG_ADDR, 16'h0000);
`endif
    drain();
    res_n = 1'b1;

`ifdef VECTOR_FETCH_EN
    pc_enable = 1'b1;
    pc_load   = 1'b1;
    data_in   = 8'h34;
    push("vec_lo_addr", SIG_ADDR, 16'hFFFC);
    push("vec_lo_busy", SIG_BUSY, 16'd1);
    drain();
    tick();
    push("vec_hi_addr", SIG_ADDR, 16'hFFFD);
    push("vec_hi_busy", SIG_BUSY, 16'd1);
    push("vec_hi_pc", SIG_PC, 16'h0000);
    drain();
    data_in = 8'h12;
    tick();
    push("vec_done_pc", SIG_PC, 16'h1234);
    push("vec_done_busy", SIG_BUSY, 16'd0);
    drain();
    pc_enable = 1'b0;
    pc_load   = 1'b0;
`endif

    pc_load       = 1'b1;
    pc_load_value = 16'hFFFE;
    push("load_fffe", SIG_PC, 16'hFFFE);
    tick();
    drain();
    pc_load   = 1'b0;
    pc_enable = 1'b1;
    push("inc_ffff", SIG_PC, 16'hFFFF);
    tick();
    drain();
    push("inc_wrap", SIG_PC, 16'h0000);
    tick();
    drain();
    push("inc_0001", SIG_PC, 16'h0001);
    tick();
    drain();

    pc_load       = 1'b1;
    pc_load_value = 16'hC000;
    push("load_wins", SIG_PC, 16'hC000);
    tick();
    drain();

    pc_enable     = 1'b0;
    pc_load_value = 16'h0200;
    push("load_0200", SIG_PC, 16'h0200);
    tick();
    drain();
    pc_load        = 1'b0;
    memory_address = 16'h1A2B;
    alu_result     = 8'h85;
    for (int s = 0; s < 4; s++) begin
      address_select = s[1:0];
      #1;
      case (s)
        1:       push("mux_mem", SIG_ADDR, 16'h1A2B);
        2:       push("mux_zp", SIG_ADDR, 16'h0085);
        default: push("mux_pc", SIG_ADDR, 16'h0200);
      endcase
      drain();
    end
    alu_result = 8'hF0;
    address_select = 2'd2;
    #1;
    push("mux_zp_f0", SIG_ADDR, 16'h00F0);
    drain();

    clk_enable     = 1'b0;
    pc_enable      = 1'b1;
    address_select = 2'd1;
    for (int i = 0; i < 4; i++) begin
      push("hold_pc", SIG_PC, 16'h0200);
      tick();
      drain();
    end
    memory_address = 16'h5555;
    #1;
    push("hold_addr_tracks", SIG_ADDR, 16'h5555);
    drain();
    clk_enable     = 1'b1;
    address_select = 2'd0;
    push("reenable_inc", SIG_PC, 16'h0201);
    tick();
    drain();
    push("reenable_addr", SIG_ADDR, 16'h0201);
    drain();
    pc_enable = 1'b0;

`ifdef VECTOR_FETCH_EN
    res_n = 1'b0;
    #2;
    res_n   = 1'b1;
    data_in = 8'h34;
    tick();
    push("midfetch_busy", SIG_BUSY, 16'd1);
    push("midfetch_addr", SIG_ADDR, 16'hFFFD);
    drain();
    res_n = 1'b0;
    #1;
    push("midreset_pc", SIG_PC, 16'h0000);
    push("midreset_addr", SIG_ADDR, 16'hFFFC);
    push("midreset_busy", SIG_BUSY, 16'd1);
    drain();
    res_n   = 1'b1;
    data_in = 8'h00;
    tick();
    data_in = 8'h80;
    tick();
    push("refetch_pc", SIG_PC, 16'h8000);
    push("refetch_busy", SIG_BUSY, 16'd0);
    drain();
`else
    res_n = 1'b0;
    #1;
    push("midrun_reset_pc", SIG_PC, 16'h0000);
    push("midrun_reset_busy", SIG_BUSY, 16'd0);
    drain();
    res_n     = 1'b1;
    pc_enable = 1'b1;
    tick();
    push("post_reset_inc", SIG_PC, 16'h0001);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/address_generation_unit.md
Name: address_generation_unit

Overview:
- Owns the 16-bit program counter and drives the external address bus, directly downstream of instruction_decode.
- Consumes the decoder's pc_enable, address_select and memory_address outputs.
- Also consumes the ALU result used for indexed zero-page addresses.
- After reset it runs a two-cycle reset-vector fetch before normal operation, and holds the decoder off via vector_busy until the fetch completes.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset; also the final PC when VECTOR_FETCH_EN is undefined.
- VECTOR_ADDR, 16'hFFFC: address of the reset-vector low byte; the high byte is at VECTOR_ADDR+1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- res_n  in  1  asynchronous active-low reset.
- clk_enable  in  1  qualifies every state/PC update; when low, all registers hold.
- pc_enable  in  1  increment PC by 1 this enabled cycle.
- pc_load  in  1  load PC from pc_load_value this enabled cycle; has priority over pc_enable.
- pc_load_value  in  16  jump target.
- address_select  in  2  0 = PC, 1 = memory_address, 2 = {8'h00, alu_result}, 3 = PC.
- memory_address  in  16  operand address from decoder.
- alu_result  in  8  ALU output for zero-page indexed addressing.
- data_in  in  8  external data bus, sampled during vector fetch.
- address_out  out  16  external address bus.
- pc_out  out  16  current PC register value.
- vector_busy  out  1  high while the vector fetch is in progress; drives the decoder's rdy low.

Behaviour:
- Reset (res_n low, asynchronous): PC = RESET_PC; vec_lo = 8'h00.
  - With VECTOR_FETCH_EN: state = S_VEC_LO, vector_busy = 1.
  - Without VECTOR_FETCH_EN: state = S_RUN, vector_busy = 0.
- address_out is combinational from registered state and current inputs:
  - S_VEC_LO: VECTOR_ADDR.
  - S_VEC_HI: VECTOR_ADDR + 1.
  - S_RUN: mux on address_select as listed under Ports.
- pc_out = PC register at all times.
- State machine; transitions occur only on clk edges with clk_enable = 1:
  - S_VEC_LO: vec_lo <= data_in; go to S_VEC_HI.
  - S_VEC_HI: PC <= {data_in, vec_lo}; go to S_RUN. vector_busy falls in the same edge.
  - S_RUN: remains in S_RUN until reset.
    - pc_load = 1: PC <= pc_load_value.
    - Else pc_enable = 1: PC <= PC + 1, modulo 2^16 (16'hFFFF -> 16'h0000, no carry out).
    - Else PC holds.
- pc_enable and pc_load are ignored in S_VEC_LO and S_VEC_HI.
- vector_busy = 1 exactly in S_VEC_LO and S_VEC_HI. Total vector latency: 2 enabled cycles after res_n deasserts.
- Latency: the PC update is visible on pc_out, and on address_out when address_select = 0, on the cycle after the enabling edge.
- Simultaneous pc_load and pc_enable: the load wins; no increment is applied.
- address_select = 2 always zero-extends alu_result; the high byte is forced to 8'h00 (zero-page wrap per 6502).
- clk_enable low: state, PC and vec_lo hold; address_out still tracks the combinational mux inputs.
- Reset asserted mid-fetch or mid-run: immediate return to reset values. A partial vec_lo is discarded.
- No X propagation: all registers have reset values; default case returns state to S_RUN.

Optional Feature:
- VECTOR_FETCH_EN defined:
  - Reset enters S_VEC_LO and the two-cycle fetch from VECTOR_ADDR/VECTOR_ADDR+1 loads PC.
- VECTOR_FETCH_EN undefined:
  - S_VEC_LO/S_VEC_HI and vec_lo are not compiled.
  - Reset enters S_RUN with PC = RESET_PC; vector_busy is tied to 0.

Test Plan:
- VECTOR_FETCH_EN, release res_n, data_in = 8'h34 then 8'h12:
  - address_out = FFFC then FFFD, vector_busy = 1 for 2 cycles.
  - Then pc_out = 16'h1234, vector_busy = 0.
- In S_RUN with PC = 16'hFFFE, pc_enable high 3 enabled cycles -> pc_out = FFFF, 0000, 0001.
- pc_load = 1, pc_enable = 1, pc_load_value = 16'hC000 on the same edge -> pc_out = 16'hC000 (not C001).
- Mux sweep with PC = 16'h0200, memory_address = 16'h1A2B, alu_result = 8'h85:
  - address_select 0 -> 0200; 1 -> 1A2B; 2 -> 0085; 3 -> 0200.
- clk_enable = 0 with pc_enable = 1 for 4 cycles -> pc_out unchanged; re-enable one cycle -> PC + 1.
- Assert res_n low in S_VEC_HI after vec_lo = 8'h34 -> immediately PC = RESET_PC, state S_VEC_LO.
  - Refetch with 8'h00/8'h80 -> pc_out = 16'h8000.
